// File: rtl/fakeram_arb_pkg.sv
// Shared constants and record types for the fakeram 64x256 dual-port arbiter.
package fakeram_arb_pkg;

  localparam int RAM_BITS   = 64;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DEPTH  = 256;
  localparam int ID_W       = 3;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_BITS-1:0]   wdata;
  } req_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            is_read;
  } grant_t;

endpackage

// File: rtl/fakeram_arb_pick2.sv
// Combinational rotating picker: first valid candidate wins port 0, the next
// candidate that does not hazard with it wins port 1.
module fakeram_arb_pick2
  import fakeram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = RAM_ADDR_W,
  parameter int IDW        = 2,
  parameter int SKW        = 3
) (
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [IDW-1:0]                i_rr_ptr,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_a_vld,
  output logic [IDW-1:0]                o_a_id,
  output logic                          o_b_vld,
  output logic [IDW-1:0]                o_b_id,
  output logic [SKW-1:0]                o_skip
);

  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] w_a_addr;
  logic                  w_a_we;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) w_addr[i] = i_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Hazarding candidates met before port 1 is filled are the ones deferred.
  always_comb begin
    logic [IDW-1:0] idx;
    o_a_vld  = 1'b0;
    o_a_id   = '0;
    o_b_vld  = 1'b0;
    o_b_id   = '0;
    o_skip   = '0;
    w_a_addr = '0;
    w_a_we   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (i_valid[idx]) begin
        if (!o_a_vld) begin
          o_a_vld  = 1'b1;
          o_a_id   = idx;
          w_a_addr = w_addr[idx];
          w_a_we   = i_we[idx];
        end else if (!o_b_vld) begin
          if ((w_addr[idx] == w_a_addr) && (w_a_we || i_we[idx])) begin
            o_skip = o_skip + 1'b1;
          end else begin
            o_b_vld = 1'b1;
            o_b_id  = idx;
          end
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (o_a_vld) o_grant[o_a_id] = 1'b1;
    if (o_b_vld) o_grant[o_b_id] = 1'b1;
  end

endmodule

// File: rtl/fakeram_w64_l256_arb.sv
// Round-robin arbiter sharing both ports of a 64x256 dual-port fakeram among
// NUM_REQ requesters, returning read data to the originator one cycle later.
module fakeram_w64_l256_arb
  import fakeram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BITS       = RAM_BITS,
  parameter int ADDR_WIDTH = RAM_ADDR_W,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BITS-1:0]       req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*BITS-1:0]       rsp_rdata,
  output logic                          ram_rw0_clk,
  output logic                          ram_rw0_ce_in,
  output logic                          ram_rw0_we_in,
  output logic [ADDR_WIDTH-1:0]         ram_rw0_addr_in,
  output logic [BITS-1:0]               ram_rw0_wd_in,
  input  logic [BITS-1:0]               ram_rw0_rd_out,
  output logic                          ram_rw1_clk,
  output logic                          ram_rw1_ce_in,
  output logic                          ram_rw1_we_in,
  output logic [ADDR_WIDTH-1:0]         ram_rw1_addr_in,
  output logic [BITS-1:0]               ram_rw1_wd_in,
  input  logic [BITS-1:0]               ram_rw1_rd_out,
  output logic [CNT_WIDTH-1:0]          conflict_cnt
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SKW = $clog2(NUM_REQ) + 1;

  req_t                 w_req [NUM_REQ];
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_a_vld, w_b_vld;
  logic [IDW-1:0]       w_a_id, w_b_id, w_last, w_ptr_nxt;
  logic [SKW-1:0]       w_skip;
  logic [IDW-1:0]       r_ptr;
  grant_t               r_g0_p1, r_g1_p1;
  logic [CNT_WIDTH-1:0] r_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [SKW-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req[i] = '{we:    req_we[i],
                   addr:  req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                   wdata: req_wdata[i*BITS +: BITS]};
    end
  end

  fakeram_arb_pick2 #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .IDW(IDW), .SKW(SKW)
  ) u_pick (
    .i_valid(req_valid), .i_we(req_we), .i_addr(req_addr), .i_rr_ptr(r_ptr),
    .o_grant(w_grant), .o_a_vld(w_a_vld), .o_a_id(w_a_id),
    .o_b_vld(w_b_vld), .o_b_id(w_b_id), .o_skip(w_skip)
  );

  assign req_ready   = w_grant;
  assign ram_rw0_clk = clk;
  assign ram_rw1_clk = clk;
  assign w_last      = w_b_vld ? w_b_id : w_a_id;
  assign w_ptr_nxt   = (w_last == IDW'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;

  // Stage p0: granted requests drive the macro ports directly.
  always_comb begin
    ram_rw0_ce_in   = w_a_vld;
    ram_rw0_we_in   = w_a_vld & w_req[w_a_id].we;
    ram_rw0_addr_in = w_a_vld ? w_req[w_a_id].addr  : '0;
    ram_rw0_wd_in   = w_a_vld ? w_req[w_a_id].wdata : '0;
    ram_rw1_ce_in   = w_b_vld;
    ram_rw1_we_in   = w_b_vld & w_req[w_b_id].we;
    ram_rw1_addr_in = w_b_vld ? w_req[w_b_id].addr  : '0;
    ram_rw1_wd_in   = w_b_vld ? w_req[w_b_id].wdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_g0_p1 <= '0;
      r_g1_p1 <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_a_vld) r_ptr <= w_ptr_nxt;
      r_g0_p1 <= '{valid: w_a_vld, id: ID_W'(w_a_id), is_read: w_a_vld & ~w_req[w_a_id].we};
      r_g1_p1 <= '{valid: w_b_vld, id: ID_W'(w_b_id), is_read: w_b_vld & ~w_req[w_b_id].we};
      r_cnt   <= sat_add(r_cnt, w_skip);
    end
  end

  // Stage p1: macro read data routed back to the requester that issued it.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_g0_p1.valid && r_g0_p1.is_read && (r_g0_p1.id == ID_W'(i))) begin
        rsp_valid[i]             = 1'b1;
        rsp_rdata[i*BITS +: BITS] = ram_rw0_rd_out;
      end
      if (r_g1_p1.valid && r_g1_p1.is_read && (r_g1_p1.id == ID_W'(i))) begin
        rsp_valid[i]             = 1'b1;
        rsp_rdata[i*BITS +: BITS] = ram_rw1_rd_out;
      end
    end
  end

  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_fakeram_w64_l256_arb.sv
// Bench for fakeram_w64_l256_arb: directed scenarios plus random traffic scored
// against a request-level model and a behavioural dual-port macro.
module tb_fakeram_w64_l256_arb;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [NR*8-1:0] req_addr;
  logic [NR*64-1:0] req_wdata, rsp_rdata;
  logic            ram_rw0_clk, ram_rw0_ce_in, ram_rw0_we_in;
  logic [7:0]      ram_rw0_addr_in;
  logic [63:0]     ram_rw0_wd_in, ram_rw0_rd_out;
  logic            ram_rw1_clk, ram_rw1_ce_in, ram_rw1_we_in;
  logic [7:0]      ram_rw1_addr_in;
  logic [63:0]     ram_rw1_wd_in, ram_rw1_rd_out;
  logic [15:0]     conflict_cnt;

  fakeram_w64_l256_arb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_rw0_clk(ram_rw0_clk), .ram_rw0_ce_in(ram_rw0_ce_in), .ram_rw0_we_in(ram_rw0_we_in),
    .ram_rw0_addr_in(ram_rw0_addr_in), .ram_rw0_wd_in(ram_rw0_wd_in), .ram_rw0_rd_out(ram_rw0_rd_out),
    .ram_rw1_clk(ram_rw1_clk), .ram_rw1_ce_in(ram_rw1_ce_in), .ram_rw1_we_in(ram_rw1_we_in),
    .ram_rw1_addr_in(ram_rw1_addr_in), .ram_rw1_wd_in(ram_rw1_wd_in), .ram_rw1_rd_out(ram_rw1_rd_out),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural macro: registered read, write on the clock edge.
  logic [63:0] ram_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = '0;
    ram_rw0_rd_out = '0;
    ram_rw1_rd_out = '0;
  end
  always @(posedge ram_rw0_clk) begin
    if (ram_rw0_ce_in) begin
      if (ram_rw0_we_in) ram_mem[ram_rw0_addr_in] <= ram_rw0_wd_in;
      else               ram_rw0_rd_out <= ram_mem[ram_rw0_addr_in];
    end
  end
  always @(posedge ram_rw1_clk) begin
    if (ram_rw1_ce_in) begin
      if (ram_rw1_we_in) ram_mem[ram_rw1_addr_in] <= ram_rw1_wd_in;
      else               ram_rw1_rd_out <= ram_mem[ram_rw1_addr_in];
    end
  end

  // Reference model state
  logic        m_v  [NR];
  logic        m_we [NR];
  logic [7:0]  m_a  [NR];
  logic [63:0] m_d  [NR];
  logic [63:0] ref_mem [256];
  logic [NR-1:0] exp_rv;
  logic [63:0] exp_rd [NR];
  int          m_ptr, m_cnt, mode;
  int          total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = m_v[i];
      req_we[i]            = m_we[i];
      req_addr[i*8 +: 8]   = m_a[i];
      req_wdata[i*64 +: 64] = m_d[i];
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [63:0] d);
    m_v[i] = 1'b1; m_we[i] = we; m_a[i] = a; m_d[i] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      m_v[i] = 1'b0; m_we[i] = 1'b0; m_a[i] = '0; m_d[i] = '0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; exp_rv = '0;
  endtask

  // One cycle: check last cycle's responses, present requests, check grants.
  task automatic step();
    int cand[$];
    int ia, ib, sk;
    logic [NR-1:0] g;
    @(negedge clk);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    for (int i = 0; i < NR; i++)
      if (exp_rv[i]) chk("rsp_rdata", rsp_rdata[i*64 +: 64], exp_rd[i]);
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    if (mode == 2) begin
      for (int i = 0; i < NR; i++)
        if (!m_v[i] && $urandom_range(0, 9) < 7)
          set_req(i, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 7)), {$urandom, $urandom});
    end
    drive();
    #1;
    for (int k = 0; k < NR; k++)
      if (m_v[(m_ptr + k) % NR]) cand.push_back((m_ptr + k) % NR);
    ia = -1; ib = -1; sk = 0; g = '0;
    if (cand.size() > 0) begin
      ia = cand[0];
      for (int j = 1; j < cand.size(); j++) begin
        if (m_a[cand[j]] == m_a[ia] && (m_we[ia] || m_we[cand[j]])) sk++;
        else begin ib = cand[j]; break; end
      end
    end
    if (ia >= 0) g[ia] = 1'b1;
    if (ib >= 0) g[ib] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(g));
    chk("rw0_ce", 64'(ram_rw0_ce_in), 64'(ia >= 0));
    chk("rw1_ce", 64'(ram_rw1_ce_in), 64'(ib >= 0));
    if (ia >= 0) begin
      chk("rw0_we", 64'(ram_rw0_we_in), 64'(m_we[ia]));
      chk("rw0_addr", 64'(ram_rw0_addr_in), 64'(m_a[ia]));
    end
    if (ib >= 0) begin
      chk("rw1_we", 64'(ram_rw1_we_in), 64'(m_we[ib]));
      chk("rw1_addr", 64'(ram_rw1_addr_in), 64'(m_a[ib]));
    end else begin
      chk("rw1_idle_addr", 64'(ram_rw1_addr_in), 64'd0);
      chk("rw1_idle_wd", ram_rw1_wd_in, 64'd0);
    end
    exp_rv = '0;
    if (ia >= 0 && !m_we[ia]) begin exp_rv[ia] = 1'b1; exp_rd[ia] = ref_mem[m_a[ia]]; end
    if (ib >= 0 && !m_we[ib]) begin exp_rv[ib] = 1'b1; exp_rd[ib] = ref_mem[m_a[ib]]; end
    if (ia >= 0 && m_we[ia]) ref_mem[m_a[ia]] = m_d[ia];
    if (ib >= 0 && m_we[ib]) ref_mem[m_a[ib]] = m_d[ib];
    if (ib >= 0)      m_ptr = (ib + 1) % NR;
    else if (ia >= 0) m_ptr = (ia + 1) % NR;
    m_cnt = (m_cnt + sk > 65535) ? 65535 : m_cnt + sk;
    if (mode != 1)
      for (int i = 0; i < NR; i++) if (g[i]) m_v[i] = 1'b0;
  endtask

  // Reset pulsed just after the edge that accepted a read.
  task automatic mid_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    clear_reqs();
    drive();
    #2;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    mode = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < NR; i++) exp_rd[i] = '0;
    clear_reqs();
    model_reset();
    drive();
    repeat (3) begin
      @(negedge clk);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_ce0", 64'(ram_rw0_ce_in), 64'd0);
      chk("reset_ce1", 64'(ram_rw1_ce_in), 64'd0);
      chk("reset_cnt", 64'(conflict_cnt), 64'd0);
    end
    rst = 1'b0;

    repeat (10) step();

    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'h40 + 8'(i), {32'hA5A5_0000 + 32'(i), $urandom});
    repeat (2) step();

    set_req(0, 1'b1, 8'h10, 64'hDEAD_BEEF_0000_0001);
    step();
    set_req(0, 1'b0, 8'h10, '0);
    step();
    step();

    set_req(1, 1'b0, 8'h41, '0);
    step();
    mid_reset();
    step();

    mode = 1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'h40 + 8'(i), '0);
    repeat (8) step();
    mode = 0;
    clear_reqs();
    step();
    step();

    set_req(0, 1'b1, 8'h20, 64'h1234_5678_9ABC_DEF0);
    set_req(1, 1'b0, 8'h20, '0);
    repeat (3) step();

    set_req(2, 1'b0, 8'h30, '0);
    set_req(3, 1'b0, 8'h30, '0);
    repeat (2) step();

    mode = 2;
    repeat (400) step();
    mode = 0;
    clear_reqs();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
